inpass_debounce_sync: RTL and testbench

//  Input conditioner between the InPass4 fabric input tile and user logic (e.g. the counter/reset path).

---
 rtl/inpass_debounce_sync.sv | 61 ++++++
 tb/tb_inpass_debounce_sync.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/inpass_debounce_sync.sv
// inpass_debounce_sync: per-bit pad synchroniser and debouncer with rise/fall event pulses
// Ports: clk; rst_n (async, active-low); pad_i raw pads; level_o debounced level;
//   rise_o/fall_o one-cycle pulses on level_o edges; pend_o sticky event flags cleared by ack_i.
// Build option INPASS_EVENT_LATCH_EN: enables pend_o/ack_i; undefined ties pend_o to 0 and ignores ack_i.
module inpass_debounce_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = $clog2(DB_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pend_o,
  input  logic [WIDTH-1:0] ack_i
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || WIDTH < 1) begin : g_bad_param
    $error("inpass_debounce_sync: illegal parameters");
  end
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0]                  s;
  assign s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  // Counter only runs while the synced bit disagrees with level_o; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      level_o <= '0;
      rise_o  <= '0;
      fall_o  <= '0;
    end else begin
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < WIDTH; i++)
        if (s[i] == level_o[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] != CNT_LAST) cnt_q[i] <= cnt_q[i] + 1'b1;
        else begin
          cnt_q[i]   <= '0;
          level_o[i] <= s[i];
          rise_o[i]  <= s[i];
          fall_o[i]  <= ~s[i];
        end
    end
`ifdef INPASS_EVENT_LATCH_EN
  // An event arriving with an ack keeps the flag set so it is never lost.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_o <= '0;
    else pend_o <= rise_o | fall_o | (pend_o & ~ack_i);
`else
  logic unused_ack;
  assign unused_ack = ^ack_i;
  assign pend_o = '0;
`endif
endmodule

// File: tb/tb_inpass_debounce_sync.sv
// tb_inpass_debounce_sync: randomized bench against a sliding-window debounce model
module tb_inpass_debounce_sync;
  localparam int SS = 2, DB = 16;
`ifdef INPASS_EVENT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] pad = '0, ack = '0, pad_b = '0;
  logic [3:0] level, rise, fall, pend, level_b, rise_b, fall_b, pend_b;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] hist[$];
  logic [3:0] mlev, mrise, mfall, mpend;
  inpass_debounce_sync #(.WIDTH(4), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .pad_i(pad), .level_o(level), .rise_o(rise),
    .fall_o(fall), .pend_o(pend), .ack_i(ack));
  inpass_debounce_sync #(.WIDTH(4), .SYNC_STAGES(3), .DB_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pad_i(pad_b), .level_o(level_b), .rise_o(rise_b),
    .fall_o(fall_b), .pend_o(pend_b), .ack_i(4'h0));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (SS + DB) hist.push_front(4'h0);
    mlev = '0; mrise = '0; mfall = '0; mpend = '0;
  endtask
  // A bit flips when the DB synced samples seen so far (pad as sampled SS..SS+DB-1 edges ago)
  // all disagree with the current level.
  task automatic tick();
    logic [3:0] flip;
    @(posedge clk);
    hist.push_front(pad);
    void'(hist.pop_back());
    flip = '1;
    for (int k = SS; k < SS + DB; k++) flip &= hist[k] ^ mlev;
    mpend = LATCH ? (mrise | mfall | (mpend & ~ack)) : 4'h0;
    mrise = flip & ~mlev;
    mfall = flip & mlev;
    mlev  = mlev ^ flip;
    #1;
    check("level", level, mlev);
    check("rise", rise, mrise);
    check("fall", fall, mfall);
    check("pend", pend, mpend);
  endtask
  initial begin
    int first0, first1, seen, got;
    model_reset();
    #3;
    check("reset_level", level, 4'h0);
    check("reset_pulses", {rise, fall}, 8'h0);
    check("reset_pend", pend, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    // SYNC_STAGES=3, DB_CYCLES=1 instance: step both directions on bit 2
    pad_b[2] = 1'b1;
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (got == 0 && level_b[2]) begin got = k; check("b_rise_pulse", rise_b, 4'h4); end
    end
    check("b_rise_latency", got, 4);
    pad_b[2] = 1'b0;
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (got == 0 && !level_b[2]) begin got = k; check("b_fall_pulse", fall_b, 4'h4); end
    end
    check("b_fall_latency", got, 4);
    // latency on bit 0 with defaults
    pad = 4'h1;
    got = 0; seen = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rise[0]) begin seen++; if (got == 0) got = k; end
    end
    check("lat_edge", got, SS + DB);
    check("lat_pulse_count", seen, 1);
    pad = 4'h0;
    repeat (30) tick();
    // glitch of 15 synced cycles on bit 1 is rejected, 16 is accepted
    pad = 4'h2;
    repeat (15) tick();
    pad = 4'h0;
    seen = 0;
    repeat (25) begin tick(); seen += int'(rise[1] | level[1]); end
    check("glitch15_rejected", seen, 0);
    pad = 4'h2;
    repeat (16) tick();
    pad = 4'h0;
    seen = 0;
    repeat (25) begin tick(); seen += int'(rise[1]); end
    check("pulse16_accepted", seen, 1);
    repeat (10) tick();
    // independence
    pad = 4'b0101;
    first0 = 0; first1 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) pad = 4'b1111;
      tick();
      if (first0 == 0 && rise[0]) first0 = k;
      if (first1 == 0 && rise[1]) first1 = k;
    end
    check("indep_bit0", first0, SS + DB);
    check("indep_skew", first1 - first0, 5);
    check("indep_level", level, 4'hF);
    // sticky flags on bit 3: set by rise, cleared by ack, event beats a simultaneous ack
    repeat (3) tick();
    check("pend_hold", pend[3], LATCH);
    ack = 4'h8; tick(); ack = 4'h0;
    check("pend_ack", pend[3], 1'b0);
    pad = 4'h7;
    got = 0;
    for (int k = 1; k <= 30 && got == 0; k++) begin tick(); if (fall[3]) got = k; end
    check("fall3_edge", got, SS + DB);
    ack = 4'h8; tick(); ack = 4'h0;
    check("pend_event_wins", pend[3], LATCH);
    // random segments with a mid-run reset
    for (int seg = 0; seg < 160; seg++) begin
      pad = 4'($urandom);
      repeat ($urandom_range(1, 30)) begin ack = 4'($urandom); tick(); end
      if (seg == 80) begin
        pad = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_level", level, 4'h0);
        check("async_reset_pulses", {rise, fall}, 8'h0);
        check("async_reset_pend", pend, 4'h0);
        repeat (3) @(posedge clk);
        model_reset();
        ack = '0;
        @(negedge clk) rst_n = 1'b1;
        got = 0;
        for (int k = 1; k <= 30; k++) begin tick(); if (got == 0 && rise == 4'hF) got = k; end
        check("reset_release_rise", got, SS + DB);
        check("reset_release_level", level, 4'hF);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
